// File: rtl/vga_pkg.sv
// Shared types, default 640x480 timing, the runtime mode table and total-count helper
// for the VGA raster timing generator.
package vga_pkg;

    localparam int TW = 16;
    typedef logic [TW-1:0] tval_t;

    typedef struct packed {
        tval_t h_display;
        tval_t h_front;
        tval_t h_sync;
        tval_t h_back;
        tval_t v_display;
        tval_t v_front;
        tval_t v_sync;
        tval_t v_back;
        logic  hsync_pol;
        logic  vsync_pol;
    } timing_t;

    typedef struct packed {
        tval_t h_total;
        tval_t v_total;
    } totals_t;

    typedef enum logic [1:0] {
        MODE_640X480 = 2'd0,
        MODE_800X600 = 2'd1,
        MODE_RSVD2   = 2'd2,
        MODE_RSVD3   = 2'd3
    } mode_e;

    typedef enum logic {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_e;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam timing_t TIMING_640X480 = '{
        h_display: tval_t'(DEF_H_DISPLAY), h_front: tval_t'(DEF_H_FRONT),
        h_sync:    tval_t'(DEF_H_SYNC),    h_back:  tval_t'(DEF_H_BACK),
        v_display: tval_t'(DEF_V_DISPLAY), v_front: tval_t'(DEF_V_FRONT),
        v_sync:    tval_t'(DEF_V_SYNC),    v_back:  tval_t'(DEF_V_BACK),
        hsync_pol: 1'b0, vsync_pol: 1'b0
    };

    localparam timing_t TIMING_800X600 = '{
        h_display: 16'd800, h_front: 16'd40, h_sync: 16'd128, h_back: 16'd88,
        v_display: 16'd600, v_front: 16'd1,  v_sync: 16'd4,   v_back: 16'd23,
        hsync_pol: 1'b1, vsync_pol: 1'b1
    };

    // Reserved codes fall back to 640x480.
    localparam timing_t MODE_TABLE [4] = '{
        TIMING_640X480, TIMING_800X600, TIMING_640X480, TIMING_640X480
    };

    function automatic totals_t vga_totals(input timing_t t);
        totals_t r;
        r.h_total = t.h_display + t.h_front + t.h_sync + t.h_back;
        r.v_total = t.v_display + t.v_front + t.v_sync + t.v_back;
        return r;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register with a parametrised reset value; aligns the
// sync/video flags with the downstream pixel pipeline.
module vga_delay_line #(
    parameter int           W       = 3,
    parameter int           DEPTH   = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ce,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] tap [DEPTH+1];

    assign tap[0] = d_i;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [W-1:0] stage_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stage_q <= RST_VAL;
            end else if (ce) begin
                stage_q <= tap[gi];
            end
        end

        assign tap[gi+1] = stage_q;
    end

    assign q_o = tap[DEPTH];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable, delayed sync/video
// flags and line/frame strobes. Define VGA_RUNTIME_MODE_EN for run-time mode selection.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_DISPLAY = DEF_H_DISPLAY,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_DISPLAY = DEF_V_DISPLAY,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CW        = 11,
    parameter int   PIPE_DLY  = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_pulse,
    output logic          frame_pulse
`ifdef VGA_RUNTIME_MODE_EN
    ,
    input  logic          cfg_valid,
    input  logic [1:0]    cfg_mode,
    output logic          cfg_ready,
    output logic [1:0]    active_mode
`endif
);

    timing_t       tm;
    totals_t       tot;
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic          line_pulse_q, line_pulse_d;
    logic          frame_pulse_q, frame_pulse_d;
    tval_t         h_ext, v_ext;
    logic          h_last, v_last;
    logic          h_active, v_active, video_act;
    logic          hs_win, vs_win;
    logic          hs0, vs0, vo0;
    logic [2:0]    pipe_q;

`ifdef VGA_RUNTIME_MODE_EN
    cfg_state_e cfg_state_q, cfg_state_d;
    logic [1:0] active_mode_q, active_mode_d;
    logic [1:0] pending_mode_q, pending_mode_d;

    localparam logic [2:0] PIPE_RST = {~TIMING_640X480.hsync_pol, ~TIMING_640X480.vsync_pol, 1'b0};

    assign tm = MODE_TABLE[active_mode_q];
`else
    localparam timing_t PARAM_TIMING = '{
        h_display: tval_t'(H_DISPLAY), h_front: tval_t'(H_FRONT),
        h_sync:    tval_t'(H_SYNC),    h_back:  tval_t'(H_BACK),
        v_display: tval_t'(V_DISPLAY), v_front: tval_t'(V_FRONT),
        v_sync:    tval_t'(V_SYNC),    v_back:  tval_t'(V_BACK),
        hsync_pol: HSYNC_POL, vsync_pol: VSYNC_POL
    };
    localparam logic [2:0] PIPE_RST = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

    assign tm = PARAM_TIMING;
`endif

    assign tot    = vga_totals(tm);
    assign h_ext  = tval_t'(h_cnt_q);
    assign v_ext  = tval_t'(v_cnt_q);
    assign h_last = (h_ext == tot.h_total - tval_t'(1));
    assign v_last = (v_ext == tot.v_total - tval_t'(1));

    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        line_pulse_d  = 1'b0;
        frame_pulse_d = 1'b0;
        if (ce) begin
            line_pulse_d  = (h_cnt_q == '0);
            frame_pulse_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + CW'(1);
            end else begin
                h_cnt_d = h_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_pulse_q  <= 1'b0;
            frame_pulse_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_pulse_q  <= line_pulse_d;
            frame_pulse_q <= frame_pulse_d;
        end
    end

    // Stage-0 decode straight from the counter registers.
    assign h_active  = (h_ext < tm.h_display);
    assign v_active  = (v_ext < tm.v_display);
    assign video_act = h_active && v_active;
    assign hs_win    = (h_ext >= tm.h_display + tm.h_front) &&
                       (h_ext <  tm.h_display + tm.h_front + tm.h_sync);
    assign vs_win    = (v_ext >= tm.v_display + tm.v_front) &&
                       (v_ext <  tm.v_display + tm.v_front + tm.v_sync);
    assign hs0       = hs_win ? tm.hsync_pol : ~tm.hsync_pol;
    assign vs0       = vs_win ? tm.vsync_pol : ~tm.vsync_pol;
    assign vo0       = video_act;

    vga_delay_line #(
        .W       (3),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (PIPE_RST)
    ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .d_i     ({hs0, vs0, vo0}),
        .q_o     (pipe_q)
    );

    assign hsync       = pipe_q[2];
    assign vsync       = pipe_q[1];
    assign video_on    = pipe_q[0];
    assign x           = video_act ? h_cnt_q : '0;
    assign y           = video_act ? v_cnt_q : '0;
    assign line_pulse  = line_pulse_q;
    assign frame_pulse = frame_pulse_q;

`ifdef VGA_RUNTIME_MODE_EN
    // A pending mode only takes effect on the frame-wrap tick, so the running frame
    // always finishes with its original timing.
    always_comb begin
        cfg_state_d    = cfg_state_q;
        active_mode_d  = active_mode_q;
        pending_mode_d = pending_mode_q;
        case (cfg_state_q)
            CFG_IDLE: begin
                if (cfg_valid) begin
                    pending_mode_d = cfg_mode;
                    cfg_state_d    = CFG_PENDING;
                end
            end
            CFG_PENDING: begin
                if (ce && h_last && v_last) begin
                    active_mode_d = pending_mode_q;
                    cfg_state_d   = CFG_IDLE;
                end
            end
            default: cfg_state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_state_q    <= CFG_IDLE;
            active_mode_q  <= 2'd0;
            pending_mode_q <= 2'd0;
        end else begin
            cfg_state_q    <= cfg_state_d;
            active_mode_q  <= active_mode_d;
            pending_mode_q <= pending_mode_d;
        end
    end

    assign cfg_ready   = (cfg_state_q == CFG_IDLE);
    assign active_mode = active_mode_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. It replaces the fixed 640x480 sync block and feeds the pixel renderer and the frame-rate logic. Additions over the fixed block:
- all timing is set by parameters;
- a pixel clock-enable input;
- selectable sync polarity;
- glitch-free registered sync and video_on, delayed to match the downstream pixel pipeline;
- line and frame strobes.

Parameters:
H_DISPLAY, 640, active pixels per line
H_FRONT, 16, horizontal front porch (ticks)
H_SYNC, 96, hsync width (ticks)
H_BACK, 48, horizontal back porch (ticks)
V_DISPLAY, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync active level (0 = active-low)
VSYNC_POL, 0, vsync active level
CW, 11, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
PIPE_DLY, 2, ce ticks by which hsync, vsync and video_on lag x/y; legal range 1..8

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
ce  in  1  pixel tick enable; the generator advances only when ce=1
x  out  CW  horizontal coordinate; 0 outside active area
y  out  CW  vertical coordinate; 0 outside active area
hsync  out  1  registered horizontal sync, delayed PIPE_DLY ticks
vsync  out  1  registered vertical sync, delayed PIPE_DLY ticks
video_on  out  1  registered active-area flag, delayed PIPE_DLY ticks
line_pulse  out  1  one-clk strobe at the start of each line
frame_pulse  out  1  one-clk strobe at the start of each frame

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
- Counters h_cnt and v_cnt (CW bits) change only when ce=1.
  - h_cnt wraps at H_TOTAL-1 to 0.
  - v_cnt increments on each h wrap and wraps at V_TOTAL-1 to 0 in the same tick as h_cnt.
- x = h_cnt and y = v_cnt when h_cnt<H_DISPLAY and v_cnt<V_DISPLAY; otherwise both are 0. Decoded directly from the counter registers, with zero added latency.
- Stage-0 signals are decoded from the counters:
  - hs0 = HSYNC_POL when H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_SYNC, else ~HSYNC_POL;
  - vs0 is the same pattern on v_cnt with VSYNC_POL;
  - vo0 = active-area flag.
- Stage-0 signals pass through a PIPE_DLY-deep register chain that shifts only when ce=1. Outputs come from the last stage, so they are glitch-free with no combinational path to the pins.
- line_pulse is registered: high for exactly one clk in the cycle after a ce tick taken with h_cnt==0; otherwise 0.
- frame_pulse: same rule with h_cnt==0 and v_cnt==0. At that tick both strobes are high together.
- ce=0: counters, delay chain and x/y hold; strobes are 0.
- Reset (asynchronous assert, mid-frame included):
  - counters go to 0; x, y = 0;
  - every delay stage and hsync/vsync go to inactive levels (~HSYNC_POL, ~VSYNC_POL);
  - video_on, line_pulse, frame_pulse = 0.
- After reset release, the first ce tick processes count (0,0), so line_pulse and frame_pulse fire on the first tick.

Optional Feature:
Macro VGA_RUNTIME_MODE_EN.
- Defined: adds ports cfg_valid (in, 1), cfg_mode (in, 2), cfg_ready (out, 1) and active_mode (out, 2). Timing is taken from the mode table in the package: 0 = 640x480, 1 = 800x600, 2/3 reserved (treated as mode 0).
  - cfg_ready=1 when no change is pending.
  - cfg_valid & cfg_ready latches cfg_mode as pending; cfg_ready then drops.
  - The pending mode is applied on the frame-wrap tick (h=H_TOTAL-1, v=V_TOTAL-1, ce=1). At that tick active_mode updates and cfg_ready returns to 1 next clk.
  - The current frame always completes with the old timing.
  - Reset: active_mode=0, nothing pending, cfg_ready=1.
- Undefined: timing comes from parameters only; these ports do not exist.

Decomposition:
- Package vga_pkg:
  - timing struct typedef (h/v display, front, sync, back; polarities);
  - default 640x480 constants;
  - mode table;
  - a function returning H_TOTAL and V_TOTAL.
- Sub-module vga_delay_line: parametrised width and depth, ce-gated shift register with reset value as a parameter. Instantiated once for {hs0, vs0, vo0}.

Test Plan:
1. Defaults, ce held 1:
   - hsync low for h=656..751, line period 800 ticks;
   - vsync low on lines 490..491;
   - frame_pulse every 420000 clk;
   - line_pulse count per frame = 525.
2. PIPE_DLY=2: video_on falls exactly 2 ticks after x reaches 639 and returns to 0; the hsync edge lags the h_cnt=656 decode by 2 ticks.
3. ce asserted 1 clk in 4: all periods scale by 4 and outputs hold between ticks; frame_pulse stays 1 clk wide.
4. Assert reset_n=0 at h=300, v=200:
   - outputs immediately read x=y=0, hsync=vsync=1, video_on=0;
   - after release, frame_pulse fires on the first ce tick.
5. HSYNC_POL=1, VSYNC_POL=1: hsync high only at h=656..751, vsync high only at lines 490..491; both low during reset.
6. VGA_RUNTIME_MODE_EN, cfg_mode=1 pulsed mid-frame:
   - cfg_ready drops and the current frame keeps 800x525;
   - next frame is 1056x628 with active_mode=1;
   - cfg_ready returns high.
